bitslice_mul_seq: RTL and testbench

Parameterised, bit-sliced sequential multiplier for the vector-multiplier experiments. Each operand arrives as WIDTH bit-planes of LANES bits; bit k of every plane belongs to lane k. All lanes are multiplied in parallel by a shift-and-add engine over WIDTH cycles, with optional two's-complement mode. It generalises the fixed 2x2-bit, 16-lane combinational multiplier into a handshaked, width- and lane-scalable block for the evaluation harness.

---
 rtl/bitslice_mul_seq.sv | 139 +++++++++++++
 tb/tb_bitslice_mul_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitslice_mul_seq.sv
// Bit-sliced sequential multiplier: every lane of a plane-packed operand set is
// multiplied in parallel by a shift-and-add engine, one multiplier plane per cycle.
// Results are exact modulo 2^(2*WIDTH) per lane; two's complement is optional.
module bitslice_mul_seq #(
  parameter int unsigned LANES = 16,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     is_signed,
  input  logic [WIDTH*LANES-1:0]   a_planes,
  input  logic [WIDTH*LANES-1:0]   b_planes,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH*LANES-1:0] y_planes,
  output logic                     busy
);

  localparam int          PW   = 2 * int'(WIDTH);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef logic [PW-1:0][LANES-1:0]    acc_t;
  typedef logic [WIDTH-1:0][LANES-1:0] opd_t;
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  acc_t            a_ext_q, acc_q, y_q;
  acc_t            a_in_ext, pp, acc_sum;
  opd_t            a_in, b_in, b_q;
  logic            sgn_q;
  logic [CntW-1:0] cnt_q;
  logic            accept, last_step, do_sub;
  logic [LANES-1:0] b_bit;

  assign a_in      = a_planes;
  assign b_in      = b_planes;
  assign accept    = in_valid & in_ready;
  assign last_step = (cnt_q == CntW'(WIDTH - 1));
  assign b_bit     = b_q[cnt_q];
  // The sign plane of b carries negative weight, so the last step subtracts.
  assign do_sub    = sgn_q & last_step;
  assign y_planes  = y_q;

  // Extend the incoming multiplicand to the full product width.
  always_comb begin
    a_in_ext = '0;
    for (int j = 0; j < PW; j++) begin
      if (j < int'(WIDTH)) begin
        a_in_ext[j] = a_in[j];
      end else begin
        a_in_ext[j] = is_signed ? a_in[WIDTH-1] : '0;
      end
    end
  end

  // Partial product for this step, shifted up by cnt planes; overflow planes drop off.
  always_comb begin
    int cnt_i;
    pp    = '0;
    cnt_i = int'(cnt_q);
    for (int j = 0; j < PW; j++) begin
      if (j >= cnt_i) begin
        pp[j] = a_ext_q[j - cnt_i] & b_bit;
      end
    end
  end

  // Plane-serial ripple adder, all lanes at once; subtract is ~pp with carry-in 1.
  always_comb begin
    logic [LANES-1:0] c;
    logic [LANES-1:0] y;
    acc_sum = '0;
    c       = {LANES{do_sub}};
    for (int j = 0; j < PW; j++) begin
      y          = do_sub ? ~pp[j] : pp[j];
      acc_sum[j] = acc_q[j] ^ y ^ c;
      c          = (acc_q[j] & y) | (c & (acc_q[j] ^ y));
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Held low while reset is asserted so no accept can be seen during reset.
        in_ready = rst_n;
        if (in_valid && rst_n) state_d = StBusy;
      end
      StBusy: begin
        busy = 1'b1;
        if (last_step) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, accumulation and result hold register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_ext_q <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else if (accept) begin
      a_ext_q <= a_in_ext;
      b_q     <= b_in;
      sgn_q   <= is_signed;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == StBusy) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + CntW'(1);
      // y only changes when a new result completes, so it survives the handshake.
      if (last_step) y_q <= acc_sum;
    end
  end

endmodule

// File: tb/tb_bitslice_mul_seq.sv
// Bench for bitslice_mul_seq: a 16-lane/2-bit and an 8-lane/4-bit instance are
// checked every cycle against a per-lane integer model, plus hand-computed results.
module tb_bitslice_mul_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [2] = '{1'b0, 1'b0};
  logic        is_signed [2] = '{1'b0, 1'b0};
  logic        out_ready [2] = '{1'b1, 1'b1};
  logic [31:0] a_pl      [2] = '{32'h0, 32'h0};
  logic [31:0] b_pl      [2] = '{32'h0, 32'h0};
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        busy      [2];
  logic [63:0] y_pl      [2];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bitslice_mul_seq #(.LANES(16), .WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .is_signed(is_signed[0]), .a_planes(a_pl[0]), .b_planes(b_pl[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .y_planes(y_pl[0]), .busy(busy[0])
  );

  bitslice_mul_seq #(.LANES(8), .WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .is_signed(is_signed[1]), .a_planes(a_pl[1]), .b_planes(b_pl[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .y_planes(y_pl[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  // Per-lane integer product, repacked into 2*W planes of L bits.
  function automatic logic [63:0] model_mul(input int n, input logic [31:0] ap,
                                            input logic [31:0] bp, input logic s);
    int L = (n == 0) ? 16 : 8;
    int W = (n == 0) ? 2 : 4;
    logic [63:0] r = '0;
    for (int k = 0; k < L; k++) begin
      longint av = 0;
      longint bv = 0;
      longint p;
      for (int i = 0; i < W; i++) begin
        av += longint'(ap[i*L+k]) << i;
        bv += longint'(bp[i*L+k]) << i;
      end
      if (s && ap[(W-1)*L+k]) av -= longint'(1) << W;
      if (s && bp[(W-1)*L+k]) bv -= longint'(1) << W;
      p = av * bv;
      for (int j = 0; j < 2 * W; j++) r[j*L+k] = p[j];
    end
    return r;
  endfunction

  // Transaction-level timing model: 0 idle, 1 computing, 2 result offered.
  int          m_st  [2] = '{0, 0};
  int          m_cnt [2] = '{0, 0};
  logic [63:0] m_res [2] = '{64'h0, 64'h0};
  logic [63:0] m_y   [2] = '{64'h0, 64'h0};

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (!rst_n) begin
        m_st[n]  <= 0;
        m_cnt[n] <= 0;
        m_y[n]   <= '0;
      end else begin
        case (m_st[n])
          0: if (in_valid[n]) begin
            m_res[n] <= model_mul(n, a_pl[n], b_pl[n], is_signed[n]);
            m_cnt[n] <= (n == 0) ? 2 : 4;
            m_st[n]  <= 1;
          end
          1: begin
            m_cnt[n] <= m_cnt[n] - 1;
            if (m_cnt[n] == 1) begin
              m_st[n] <= 2;
              m_y[n]  <= m_res[n];
            end
          end
          default: if (out_ready[n]) m_st[n] <= 0;
        endcase
      end
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        chk(n == 0 ? "w2.in_ready" : "w4.in_ready", 64'(in_ready[n]),
            64'(rst_n && (m_st[n] == 0)));
        chk(n == 0 ? "w2.out_valid" : "w4.out_valid", 64'(out_valid[n]), 64'(m_st[n] == 2));
        chk(n == 0 ? "w2.busy" : "w4.busy", 64'(busy[n]), 64'(m_st[n] == 1));
        chk(n == 0 ? "w2.y" : "w4.y", y_pl[n], m_y[n]);
      end
    end
  end

  // Present an operand set, wait for the accept edge, then scramble the inputs.
  task automatic send(input int n, input logic [31:0] a, input logic [31:0] b, input logic s);
    int waited = 0;
    in_valid[n]  = 1'b1;
    a_pl[n]      = a;
    b_pl[n]      = b;
    is_signed[n] = s;
    while (!in_ready[n] && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready[n]) timeout("accept");
    @(posedge clk);
    #1;
    in_valid[n]  = 1'b0;
    a_pl[n]      = $urandom;
    b_pl[n]      = $urandom;
    is_signed[n] = 1'($urandom);
  endtask

  task automatic wait_result(input int n, output int lat);
    lat = 0;
    while (!out_valid[n] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid[n]) timeout("result");
  endtask

  task automatic run(input int n, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [63:0] exp_y, input string name);
    int lat;
    send(n, a, b, s);
    wait_result(n, lat);
    chk({name, ".latency"}, 64'(lat), (n == 0) ? 64'd2 : 64'd4);
    chk({name, ".y"}, y_pl[n], exp_y);
  endtask

  initial begin
    int lat;
    logic [63:0] saved;
    logic [31:0] ra, rb;

    // Pin the model to hand-computed products.
    chk("model.w2u", model_mul(0, 32'hFF00F0F0, 32'hCCCCAAAA, 1'b0), 64'h8000_4C00_6AC0_A0A0);
    chk("model.w2s", model_mul(0, 32'hFF00F0F0, 32'hCCCCAAAA, 1'b1), 64'h22C0_26C0_6AC0_A0A0);
    chk("model.w4u", model_mul(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0), 64'hFFFF_FF00_0000_00FF);
    chk("model.w4s", model_mul(1, 32'hFF000000, 32'hFF000000, 1'b1), 64'h00FF_0000_0000_0000);

    // Reset state.
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.y", y_pl[0], 64'h0);
    chk("reset.in_ready", 64'(in_ready[0]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release.in_ready", 64'(in_ready[0]), 64'd1);

    // Directed vectors with literal results.
    run(0, 32'hFF00F0F0, 32'hCCCCAAAA, 1'b0, 64'h8000_4C00_6AC0_A0A0, "w2u");
    run(0, 32'hFF00F0F0, 32'hCCCCAAAA, 1'b1, 64'h22C0_26C0_6AC0_A0A0, "w2s");
    run(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFF_FF00_0000_00FF, "w4u");
    run(1, 32'hFF000000, 32'hFF000000, 1'b1, 64'h00FF_0000_0000_0000, "w4s");

    // Further vectors against the model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      run(i % 2, ra, rb, 1'((i / 2) % 2), model_mul(i % 2, ra, rb, 1'((i / 2) % 2)), "mix");
    end

    // Backpressure: result held, no accept while DONE, even with in_valid pulsing.
    out_ready[0] = 1'b0;
    send(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    wait_result(0, lat);
    saved = y_pl[0];
    chk("bp.y", saved, model_mul(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0));
    a_pl[0]      = 32'hDEADBEEF;
    b_pl[0]      = 32'h0F0F3C3C;
    is_signed[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'(i % 2 == 0);
      @(posedge clk);
      #1;
      chk("bp.hold_y", y_pl[0], saved);
      chk("bp.hold_valid", 64'(out_valid[0]), 64'd1);
      chk("bp.hold_ready", 64'(in_ready[0]), 64'd0);
    end
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.drain_valid", 64'(out_valid[0]), 64'd0);
    chk("bp.drain_busy", 64'(busy[0]), 64'd0);
    chk("bp.drain_ready", 64'(in_ready[0]), 64'd1);
    chk("bp.drain_y", y_pl[0], saved);
    @(posedge clk);
    #1;
    chk("bp.next_busy", 64'(busy[0]), 64'd1);
    in_valid[0] = 1'b0;
    wait_result(0, lat);
    chk("bp.next_latency", 64'(lat), 64'd2);
    chk("bp.next_y", y_pl[0], model_mul(0, 32'hDEADBEEF, 32'h0F0F3C3C, 1'b1));

    // Reset while computing: result dropped.
    @(posedge clk);
    #1;
    send(0, 32'hFF00F0F0, 32'hCCCCAAAA, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.valid", 64'(out_valid[0]), 64'd0);
    chk("rst.y", y_pl[0], 64'h0);
    chk("rst.busy", 64'(busy[0]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready[0]), 64'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("rst.no_valid", 64'(out_valid[0]), 64'd0);
    end
    run(0, 32'hFF00F0F0, 32'hCCCCAAAA, 1'b0, 64'h8000_4C00_6AC0_A0A0, "rst.after");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
